mix_columns_seq: RTL and testbench
==================================

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 Parameter: COLS_PER_CYCLE, default 1, number of 32-bit columns transformed per compute cycle; legal values 1, 2, 4.
REQ-002 Parameter: NUM_STEPS, derived (not overridable), equal to 4/COLS_PER_CYCLE.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-low reset (0 = reset), sampled on clk rising edge.
REQ-005 Port: in_valid  input  1  upstream presents a state block.
REQ-006 Port: in_ready  output  1  block can accept a state.
REQ-007 Port: in_inv  input  1  mode for the offered block: 0 = MixColumns, 1 = InvMixColumns.
REQ-008 Port: x  input  128  input state; column i = x[32i+31:32i]; byte j of column i (a_j) = x[32i+8j+7:32i+8j].
REQ-009 Port: out_valid  output  1  z holds a finished result.
REQ-010 Port: out_ready  input  1  downstream accepts z.
REQ-011 Port: z  output  128  result state, same byte/column mapping as x.
REQ-012 Port: busy  output  1  high while in BUSY state.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==BUSY).
REQ-014 IDLE: on in_valid=1, x and in_inv are latched into an internal 128-bit state register and mode flag, step counter cleared to 0, go to BUSY; in_valid=0 stays IDLE.
REQ-015 BUSY: each cycle transforms columns [step*COLS_PER_CYCLE .. step*COLS_PER_CYCLE+COLS_PER_CYCLE-1] in place, column 0 first; counter increments; after step NUM_STEPS-1 go to DONE.
REQ-016 Latency: out_valid rises exactly NUM_STEPS+1 cycles after the cycle where in_valid&in_ready was sampled high (2, 3, 5 cycles for COLS_PER_CYCLE 4, 2, 1).
REQ-017 DONE: z and out_valid held stable until out_ready=1 is sampled; then go to IDLE; no simultaneous accept of a new input in that cycle.
REQ-018 z SHALL be driven from the internal state register; it reflects partial results during BUSY and is valid only when out_valid=1.
REQ-019 Forward column transform: t = a0^a1^a2^a3; b0 = a0^t^xtime(a0^a1); b1 = a1^t^xtime(a1^a2); b2 = a2^t^xtime(a2^a3); b3 = a3^t^xtime(a3^a0).
REQ-020 xtime(a) = (a<<1)[7:0] ^ (a[7] ? 8'h1B : 8'h00), all arithmetic 8-bit in GF(2^8).
REQ-021 Inverse transform: u = xtime(xtime(a0^a2)), v = xtime(xtime(a1^a3)); a0'=a0^u, a1'=a1^v, a2'=a2^u, a3'=a3^v; then apply REQ-019 to a0'..a3'; done in the same single compute cycle per column.
REQ-022 Mode flag latched at acceptance SHALL govern the whole block; in_inv changes during BUSY/DONE have no effect.
REQ-023 x changes after acceptance SHALL have no effect on the result.
REQ-024 in_valid asserted during BUSY or DONE is ignored (not latched, no backpressure loss since in_ready=0).
REQ-025 Any unsupported COLS_PER_CYCLE value is out of scope; no behaviour defined.

Reset
REQ-026 rst=0 at a rising edge SHALL force state IDLE, step counter 0, mode flag 0, internal state register (z) 128'h0, regardless of current state.
REQ-027 Post-reset outputs: in_ready=1, out_valid=0, busy=0, z=128'h0; reset mid-BUSY or mid-DONE discards the block with no output.
REQ-028 rst has priority over in_valid and out_ready in the same cycle.

Verification
REQ-029 Forward known-answer: column words 32'h455313db, 32'h5c220af2, 32'h01010101, 32'hc6c6c6c6 (cols 0..3), in_inv=0 -> z columns 32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6, out_valid at NUM_STEPS+1 cycles.
REQ-030 Inverse known-answer: columns 32'hbca14d8e, 32'h9d58dc9f, 32'h01010101, 32'hc6c6c6c6, in_inv=1 -> z columns 32'h455313db, 32'h5c220af2, 32'h01010101, 32'hc6c6c6c6.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE -> z and out_valid stable, in_ready=0, new in_valid/x ignored; out_ready=1 -> IDLE next cycle.
REQ-032 Reset mid-operation: assert rst=0 during step 1 of BUSY (COLS_PER_CYCLE=1) -> next cycle IDLE, z=0, no out_valid; following block processes correctly.
REQ-033 Random round-trip: 1000 random states, forward then inverse via back-to-back transfers, for COLS_PER_CYCLE in {1,2,4} -> output equals original input, latency per REQ-016.

Source files
------------

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns / InvMixColumns over a 128-bit state.
// COLS_PER_CYCLE columns are transformed per compute cycle.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] z,
    output logic         busy
);

    localparam int         NUM_STEPS = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_STEP = 2'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [1:0]        step;
    logic              mode;
    logic [3:0][31:0]  cols;
    logic [3:0][31:0]  cols_next;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Inverse is folded into the forward network by pre-mixing with
    // xtime^2 terms, so both modes cost one pass per column.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3, t, u, v;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        if (inv) begin
            u  = xtime(xtime(a0 ^ a2));
            v  = xtime(xtime(a1 ^ a3));
            a0 = a0 ^ u;
            a1 = a1 ^ v;
            a2 = a2 ^ u;
            a3 = a3 ^ v;
        end
        t = a0 ^ a1 ^ a2 ^ a3;
        return {a3 ^ t ^ xtime(a3 ^ a0),
                a2 ^ t ^ xtime(a2 ^ a3),
                a1 ^ t ^ xtime(a1 ^ a2),
                a0 ^ t ^ xtime(a0 ^ a1)};
    endfunction

    // NOTE: every register here uses <= so all state updates see the
    // pre-edge values of one another, independent of statement order.
    // NOTE: the data register is reset too, because z is observable and
    // must read as zero after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            step  <= '0;
            mode  <= 1'b0;
            cols  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cols <= x;
                        mode <= in_inv;
                        step <= '0;
                    end
                end
                BUSY: begin
                    cols <= cols_next;
                    step <= step + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: defaults at the top of each always_comb keep every path
    // assigned, so no latches are inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = BUSY;
            BUSY:    if (step == LAST_STEP) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Only the columns belonging to the current step are rewritten.
    always_comb begin
        cols_next = cols;
        for (int i = 0; i < 4; i++) begin
            if ((i / COLS_PER_CYCLE) == int'(step)) begin
                cols_next[i] = mix_col(cols[i], mode);
            end
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == BUSY);
        z         = cols;
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle)
// exercised with known-answer vectors, handshake corner cases and round trips.
module tb_mix_columns_seq;

    localparam logic [127:0] KAT_PLAIN = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
    localparam logic [127:0] KAT_MIXED = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
    localparam logic [127:0] KAT_STEP1 = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'hbca14d8e};
    localparam int           ITERS     = 1000;

    logic         clk;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_inv    [3];
    logic [127:0] x         [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] z         [3];
    logic         busy      [3];

    int checks;
    int failures;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_inv    (in_inv[g]),
            .x         (x[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .z         (z[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int num_steps(input int k);
        return 4 >> k;
    endfunction

    // Pushes one block through instance k, scrambling x/in_inv right after
    // acceptance; lat is the number of edges after acceptance until out_valid.
    task automatic run_block(input int k, input logic [127:0] din, input logic inv,
                             output logic [127:0] dout, output int lat);
        int n;
        n = 0;
        while (!in_ready[k] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid[k] = 1'b1;
        x[k]        = din;
        in_inv[k]   = inv;
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        x[k]        = {$urandom, $urandom, $urandom, $urandom};
        in_inv[k]   = ~inv;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (out_valid[k]) begin
                lat = c;
                break;
            end
        end
        dout         = z[k];
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks += 4;
            if (in_ready[k] !== 1'b1) begin
                failures++;
                $display("FAIL reset_in_ready[%0d]: got %b want 1", k, in_ready[k]);
            end
            if (out_valid[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_out_valid[%0d]: got %b want 0", k, out_valid[k]);
            end
            if (busy[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy[%0d]: got %b want 0", k, busy[k]);
            end
            if (z[k] !== 128'h0) begin
                failures++;
                $display("FAIL reset_z[%0d]: got %h want 0", k, z[k]);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_kat(input logic inv);
        logic [127:0] din, want, got;
        int lat;
        din  = inv ? KAT_MIXED : KAT_PLAIN;
        want = inv ? KAT_PLAIN : KAT_MIXED;
        for (int k = 0; k < 3; k++) begin
            run_block(k, din, inv, got, lat);
            checks += 2;
            if (got !== want) begin
                failures++;
                $display("FAIL kat_inv%0d_z[%0d]: got %h want %h", inv, k, got, want);
            end
            if (lat != num_steps(k)) begin
                failures++;
                $display("FAIL kat_inv%0d_latency[%0d]: got %0d want %0d", inv, k, lat, num_steps(k));
            end
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] held;
        int n;
        in_valid[0] = 1'b1;
        x[0]        = KAT_PLAIN;
        in_inv[0]   = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        checks += 3;
        if (busy[0] !== 1'b1) begin
            failures++;
            $display("FAIL bp_busy: got %b want 1", busy[0]);
        end
        if (in_ready[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_busy_in_ready: got %b want 0", in_ready[0]);
        end
        @(posedge clk); #1;
        if (z[0] !== KAT_STEP1) begin
            failures++;
            $display("FAIL bp_partial_z: got %h want %h", z[0], KAT_STEP1);
        end
        n = 0;
        while (!out_valid[0] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        held        = z[0];
        in_valid[0] = 1'b1;
        in_inv[0]   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            x[0] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || busy[0] !== 1'b0 || z[0] !== KAT_MIXED) begin
                failures++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b in_ready=%b busy=%b z=%h want 1/0/0/%h",
                         c, out_valid[0], in_ready[0], busy[0], z[0], KAT_MIXED);
            end
        end
        checks++;
        if (held !== KAT_MIXED) begin
            failures++;
            $display("FAIL bp_done_z: got %h want %h", held, KAT_MIXED);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b want 1/0/0",
                     in_ready[0], out_valid[0], busy[0]);
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] got;
        int lat, n;
        in_valid[0] = 1'b1;
        x[0]        = KAT_PLAIN;
        in_inv[0]   = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0 || z[0] !== 128'h0) begin
            failures++;
            $display("FAIL rst_busy: in_ready=%b busy=%b out_valid=%b z=%h want 1/0/0/0",
                     in_ready[0], busy[0], out_valid[0], z[0]);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid[0] !== 1'b0) begin
                failures++;
                $display("FAIL rst_busy_no_output cycle %0d: got %b want 0", c, out_valid[0]);
            end
        end
        run_block(0, KAT_PLAIN, 1'b0, got, lat);
        checks++;
        if (got !== KAT_MIXED || lat != 4) begin
            failures++;
            $display("FAIL rst_busy_next_block: z=%h lat=%0d want %h lat=4", got, lat, KAT_MIXED);
        end
        in_valid[2] = 1'b1;
        x[2]        = KAT_PLAIN;
        in_inv[2]   = 1'b0;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        n = 0;
        while (!out_valid[2] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready[2] = 1'b1;
        rst          = 1'b0;
        @(posedge clk); #1;
        rst          = 1'b1;
        out_ready[2] = 1'b0;
        checks++;
        if (in_ready[2] !== 1'b1 || out_valid[2] !== 1'b0 || z[2] !== 128'h0) begin
            failures++;
            $display("FAIL rst_done: in_ready=%b out_valid=%b z=%h want 1/0/0",
                     in_ready[2], out_valid[2], z[2]);
        end
    endtask

    task automatic test_round_trip;
        logic [127:0] orig, fwd, back;
        int lat_f, lat_b;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ITERS; i++) begin
                orig = {$urandom, $urandom, $urandom, $urandom};
                run_block(k, orig, 1'b0, fwd, lat_f);
                run_block(k, fwd, 1'b1, back, lat_b);
                checks++;
                if (back !== orig || lat_f != num_steps(k) || lat_b != num_steps(k)) begin
                    failures++;
                    $display("FAIL round_trip[%0d] iter %0d: got %h lat %0d/%0d want %h lat %0d",
                             k, i, back, lat_f, lat_b, orig, num_steps(k));
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_inv[k]    = 1'b0;
            x[k]         = '0;
            out_ready[k] = 1'b0;
        end
        test_reset();
        test_kat(1'b0);
        test_kat(1'b1);
        test_backpressure();
        test_reset_mid();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
